// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue sequencer between decode and the ALU execute stage.
// Decoded micro-ops queue in a small FIFO. A single registered "slot" drives
// the ALU inputs. Multiplies get an operand-hold window before their enable
// cycle. Branch-class ops stall issue until the branch resolves, and a taken
// branch squashes every younger op still queued.
module alu_issue_ctrl #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 2,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9:0]        in_opcode,
  input  logic [DATA_W-1:0] in_oprd1,
  input  logic [DATA_W-1:0] in_oprd2,
  input  logic [DATA_W-1:0] in_oprd3,
  input  logic [DATA_W-1:0] in_next_rip,
  output logic              alu_enable,
  output logic [9:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_oprd1,
  output logic [DATA_W-1:0] alu_oprd2,
  output logic [DATA_W-1:0] alu_oprd3,
  output logic [DATA_W-1:0] alu_next_rip,
  input  logic              mem_blocked,
  input  logic              alu_branch,
  output logic              flush,
  output logic [31:0]       issued_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int HW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam bit MUL_MULTI = (MUL_LAT > 1);
  // Hold cycles with enable low, minus the cycle that reaches zero.
  localparam logic [HW-1:0] HOLD_INIT = MUL_MULTI ? HW'(MUL_LAT - 2) : '0;

  typedef enum logic [1:0] {RUN, MUL_HOLD, BR_WAIT} state_t;

  typedef struct packed {
    logic [9:0]        opcode;
    logic [DATA_W-1:0] oprd1;
    logic [DATA_W-1:0] oprd2;
    logic [DATA_W-1:0] oprd3;
    logic [DATA_W-1:0] next_rip;
  } uop_t;

  function automatic logic is_mul(input logic [9:0] op);
    return (op == 10'h0F7) || (op == 10'h1AF);
  endfunction

  function automatic logic is_br(input logic [9:0] op);
    return (op[9:4] == 6'h07) || (op == 10'h0E9) || (op == 10'h0EB) ||
           (op[9:4] == 6'h18);
  endfunction

  uop_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  state_t          state;
  logic [HW-1:0]   hold_cnt;

  uop_t            in_op, head;
  logic            full, empty, consume, resolve, load, push;

  assign in_op    = '{in_opcode, in_oprd1, in_oprd2, in_oprd3, in_next_rip};
  assign head     = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // in_ready reflects the pre-pop occupancy; a same-edge pop is not bypassed.
  assign in_ready = !full;
  assign consume  = alu_enable && !mem_blocked;
  // Resolve cycle: the branch's enable was consumed and its outcome is visible.
  assign resolve  = (state == BR_WAIT) && !alu_enable;
  assign flush    = resolve && alu_branch;
  // The slot never changes while memory is blocked; in RUN an enabled slot is
  // always being consumed when not blocked, so the slot is free to reload.
  assign load     = !mem_blocked && !empty &&
                    ((state == RUN) || (resolve && !alu_branch));
  assign push     = in_valid && in_ready && !flush;

  // FIFO storage: payload only, no reset.
  // NOTE: the entry array is deliberately not reset; validity lives in the
  // pointers and count, so resetting wide storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_op;
  end

  // FIFO pointers and occupancy; a taken branch empties the queue.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM: slot load, multiply hold window, branch wait, issue count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      hold_cnt     <= '0;
      alu_enable   <= 1'b0;
      alu_opcode   <= '0;
      alu_oprd1    <= '0;
      alu_oprd2    <= '0;
      alu_oprd3    <= '0;
      alu_next_rip <= '0;
      issued_cnt   <= '0;
    end else begin
      if (consume) issued_cnt <= issued_cnt + 32'd1;
      if (load) begin
        alu_opcode   <= head.opcode;
        alu_oprd1    <= head.oprd1;
        alu_oprd2    <= head.oprd2;
        alu_oprd3    <= head.oprd3;
        alu_next_rip <= head.next_rip;
        if (MUL_MULTI && is_mul(head.opcode)) begin
          alu_enable <= 1'b0;
          hold_cnt   <= HOLD_INIT;
          state      <= MUL_HOLD;
        end else begin
          alu_enable <= 1'b1;
          state      <= is_br(head.opcode) ? BR_WAIT : RUN;
        end
      end else begin
        case (state)
          RUN: begin
            if (consume) alu_enable <= 1'b0;
          end
          MUL_HOLD: begin
            if (!mem_blocked) begin
              if (hold_cnt == '0) begin
                alu_enable <= 1'b1;
                state      <= RUN;
              end else begin
                hold_cnt <= hold_cnt - HW'(1);
              end
            end
          end
          BR_WAIT: begin
            if (alu_enable) begin
              if (consume) alu_enable <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule
